// File: rtl/dram_frame_reader.sv
// dram_frame_reader: AXI3 read master fetching a frame as 16-beat x 64-bit INCR bursts.
// Optional `DRAM_FRAME_READER_ERR_EN adds a sticky rd_err on non-OKAY RRESP (tied 0 otherwise).
module dram_frame_reader #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int SPACE_W         = 8
) (
  input  logic               fclk,
  input  logic               rst_n,
  output logic               M2S_AXI_ACLK,
  output logic [31:0]        M2S_AXI_ARADDR,
  output logic               M2S_AXI_ARVALID,
  input  logic               M2S_AXI_ARREADY,
  output logic [3:0]         M2S_AXI_ARLEN,
  output logic [1:0]         M2S_AXI_ARSIZE,
  output logic [1:0]         M2S_AXI_ARBURST,
  input  logic [63:0]        M2S_AXI_RDATA,
  input  logic [1:0]         M2S_AXI_RRESP,
  input  logic               M2S_AXI_RLAST,
  input  logic               M2S_AXI_RVALID,
  output logic               M2S_AXI_RREADY,
  input  logic               rd_frame_valid,
  output logic               rd_frame_ready,
  input  logic [31:0]        rd_BUF_ADDR,
  input  logic [31:0]        rd_FRAME_BYTES,
  output logic [63:0]        dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_frame_last,
  input  logic [SPACE_W-1:0] dout_space,
  output logic               frame_done,
  output logic               rd_err,
  output logic [1:0]         debug_astate
);

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_ISSUE = 2'd1,
    A_DRAIN = 2'd2
  } aState_t;

  localparam logic [2:0] OUT_MAX = 3'(MAX_OUTSTANDING);

  aState_t     aState_q;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [2:0]  outstanding_q;
  logic [2:0]  outstanding_d;
  logic [24:0] burstsLeft_q;
  logic [24:0] beatsFrame_q;
  logic [24:0] rDone_q;
  logic        frameDone_q;

  logic        arFire;
  logic        rFire;
  logic        rLastFire;
  logic        acceptFire;
  logic        canIssue;
  logic [3:0]  outPlusOne;
  logic [31:0] spaceNeed;
  logic [31:0] spaceHave;
  logic        unusedBits;

  assign arFire     = arvalid_q && M2S_AXI_ARREADY;
  assign rFire      = M2S_AXI_RVALID && dout_ready;
  assign rLastFire  = rFire && M2S_AXI_RLAST;
  assign acceptFire = rd_frame_valid && rd_frame_ready;

  // A burst is only requested once the downstream FIFO can absorb it plus every burst still in flight.
  assign outPlusOne = {1'b0, outstanding_q} + 4'd1;
  assign spaceNeed  = {24'd0, outPlusOne, 4'd0};
  assign spaceHave  = 32'(dout_space);
  assign canIssue   = !arvalid_q && (outstanding_q < OUT_MAX) && (spaceHave >= spaceNeed);

  always_comb begin
    outstanding_d = outstanding_q;
    if (arFire && !rLastFire) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (!arFire && rLastFire && (outstanding_q != 3'd0)) begin
      outstanding_d = outstanding_q - 3'd1;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      aState_q      <= A_IDLE;
      arvalid_q     <= 1'b0;
      araddr_q      <= 32'd0;
      outstanding_q <= 3'd0;
      burstsLeft_q  <= 25'd0;
      beatsFrame_q  <= 25'd0;
      rDone_q       <= 25'd0;
      frameDone_q   <= 1'b0;
    end else begin
      frameDone_q   <= 1'b0;
      outstanding_q <= outstanding_d;
      if (rLastFire) begin
        rDone_q <= rDone_q + 25'd1;
      end
      case (aState_q)
        A_IDLE: begin
          if (acceptFire) begin
            araddr_q     <= rd_BUF_ADDR;
            burstsLeft_q <= rd_FRAME_BYTES[31:7];
            beatsFrame_q <= rd_FRAME_BYTES[31:7];
            rDone_q      <= 25'd0;
            // An empty frame completes immediately without touching the AR channel.
            if (rd_FRAME_BYTES[31:7] == 25'd0) begin
              frameDone_q <= 1'b1;
            end else begin
              aState_q <= A_ISSUE;
            end
          end
        end
        A_ISSUE: begin
          if (arFire) begin
            arvalid_q    <= 1'b0;
            araddr_q     <= araddr_q + 32'd128;
            burstsLeft_q <= burstsLeft_q - 25'd1;
            if (burstsLeft_q == 25'd1) begin
              aState_q <= A_DRAIN;
            end
          end else if (canIssue) begin
            arvalid_q <= 1'b1;
          end
        end
        A_DRAIN: begin
          if (outstanding_q == 3'd0) begin
            aState_q    <= A_IDLE;
            frameDone_q <= 1'b1;
          end
        end
        default: begin
          aState_q  <= A_IDLE;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef DRAM_FRAME_READER_ERR_EN
  logic rdErr_q;

  // Error is sticky for the whole frame; data keeps flowing regardless.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rdErr_q <= 1'b0;
    end else if (rFire && (M2S_AXI_RRESP != 2'b00)) begin
      rdErr_q <= 1'b1;
    end else if (acceptFire) begin
      rdErr_q <= 1'b0;
    end
  end

  assign rd_err     = rdErr_q;
  assign unusedBits = ^rd_FRAME_BYTES[6:0];
`else
  assign rd_err     = 1'b0;
  assign unusedBits = ^{rd_FRAME_BYTES[6:0], M2S_AXI_RRESP};
`endif

  assign M2S_AXI_ACLK    = fclk;
  assign M2S_AXI_ARADDR  = araddr_q;
  assign M2S_AXI_ARVALID = arvalid_q;
  assign M2S_AXI_ARLEN   = 4'hF;
  assign M2S_AXI_ARSIZE  = 2'b11;
  assign M2S_AXI_ARBURST = 2'b01;
  assign M2S_AXI_RREADY  = dout_ready;

  assign rd_frame_ready  = (aState_q == A_IDLE);
  assign dout            = M2S_AXI_RDATA;
  assign dout_valid      = M2S_AXI_RVALID;
  assign dout_frame_last = M2S_AXI_RVALID && M2S_AXI_RLAST && (rDone_q == beatsFrame_q - 25'd1);
  assign frame_done      = frameDone_q;
  assign debug_astate    = aState_q;

endmodule

// File: tb/tb_dram_frame_reader.sv
// tb_dram_frame_reader: directed bench for dram_frame_reader with a small AXI read slave model.
// RDATA of each beat is {burst address, 28'h0, beat index} so ordering and addressing are visible.
module tb_dram_frame_reader;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic        arreadyIn;
  logic [63:0] rdataIn;
  logic [1:0]  rrespIn;
  logic        rlastIn;
  logic        rvalidIn;
  logic        doutReady;
  logic        rdFrameValid;
  logic [31:0] rdBufAddr;
  logic [31:0] rdFrameBytes;
  logic [7:0]  doutSpace;

  logic        axiAclk;
  logic [31:0] araddr;
  logic        arvalid;
  logic [3:0]  arlen;
  logic [1:0]  arsize;
  logic [1:0]  arburst;
  logic        rready;
  logic        rdFrameReady;
  logic [63:0] dout;
  logic        doutValid;
  logic        doutFrameLast;
  logic        frameDone;
  logic        rdErr;
  logic [1:0]  debugAstate;

  int passCount = 0;
  int checkCount = 0;

  int arreadyMode = 1;
  int readyMode = 1;
  int rEnable = 1;
  int errBeat = -1;

  logic [31:0] arAddrQ[$];
  int          arStamp[$];
  logic [31:0] rBursts[$];
  logic [63:0] beatQ[$];
  int beatIdx = 0;
  int beatCount = 0;
  int frameLastCount = 0;
  int frameLastIdx = -1;
  int doneCount = 0;
  int arStableViol = 0;
  int arStallCycles = 0;
  int rreadyViol = 0;
  int passViol = 0;
  logic        prevArPending = 1'b0;
  logic [31:0] prevAraddr = 32'd0;

`ifdef DRAM_FRAME_READER_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  dram_frame_reader #(.MAX_OUTSTANDING(2), .SPACE_W(8)) dut (
    .fclk           (fclk),
    .rst_n          (rst_n),
    .M2S_AXI_ACLK   (axiAclk),
    .M2S_AXI_ARADDR (araddr),
    .M2S_AXI_ARVALID(arvalid),
    .M2S_AXI_ARREADY(arreadyIn),
    .M2S_AXI_ARLEN  (arlen),
    .M2S_AXI_ARSIZE (arsize),
    .M2S_AXI_ARBURST(arburst),
    .M2S_AXI_RDATA  (rdataIn),
    .M2S_AXI_RRESP  (rrespIn),
    .M2S_AXI_RLAST  (rlastIn),
    .M2S_AXI_RVALID (rvalidIn),
    .M2S_AXI_RREADY (rready),
    .rd_frame_valid (rdFrameValid),
    .rd_frame_ready (rdFrameReady),
    .rd_BUF_ADDR    (rdBufAddr),
    .rd_FRAME_BYTES (rdFrameBytes),
    .dout           (dout),
    .dout_valid     (doutValid),
    .dout_ready     (doutReady),
    .dout_frame_last(doutFrameLast),
    .dout_space     (doutSpace),
    .frame_done     (frameDone),
    .rd_err         (rdErr),
    .debug_astate   (debugAstate)
  );

  always #5 fclk = ~fclk;

  // Slave model: drives ARREADY/R channel on the falling edge, then records what the next rising edge will see.
  always begin
    @(negedge fclk);
    arreadyIn = (arreadyMode != 0);
    if (readyMode == 2) doutReady = ~doutReady;
    else doutReady = (readyMode != 0);
    if (!rst_n) begin
      rBursts.delete();
      beatIdx = 0;
    end
    if (rEnable != 0 && rBursts.size() > 0) begin
      rvalidIn = 1'b1;
      rdataIn  = {rBursts[0], 28'h0, beatIdx[3:0]};
      rlastIn  = (beatIdx == 15);
      rrespIn  = (errBeat == beatCount) ? 2'b10 : 2'b00;
    end else begin
      rvalidIn = 1'b0;
      rdataIn  = 64'd0;
      rlastIn  = 1'b0;
      rrespIn  = 2'b00;
    end
    #1;
    if (rst_n) begin
      if (prevArPending && (!arvalid || araddr != prevAraddr)) arStableViol++;
      prevArPending = arvalid && !arreadyIn;
      prevAraddr    = araddr;
      if (arvalid && !arreadyIn) arStallCycles++;
      if (arvalid && arreadyIn) begin
        arAddrQ.push_back(araddr);
        arStamp.push_back(beatCount);
        rBursts.push_back(araddr);
      end
      if (rready != doutReady) rreadyViol++;
      if (doutValid != rvalidIn || dout != rdataIn) passViol++;
      if (rvalidIn && doutReady) begin
        beatQ.push_back(dout);
        if (doutFrameLast) begin
          frameLastCount++;
          frameLastIdx = beatCount;
        end
        beatCount++;
        if (rlastIn) begin
          void'(rBursts.pop_front());
          beatIdx = 0;
        end else begin
          beatIdx++;
        end
      end
      if (frameDone) doneCount++;
    end else begin
      prevArPending = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic clearMon();
    arAddrQ.delete();
    arStamp.delete();
    beatQ.delete();
    beatCount = 0;
    frameLastCount = 0;
    frameLastIdx = -1;
    doneCount = 0;
    arStableViol = 0;
    arStallCycles = 0;
    rreadyViol = 0;
    passViol = 0;
  endtask

  function automatic logic [31:0] arAt(input int i);
    return (arAddrQ.size() > i) ? arAddrQ[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] bytes);
    int n = 0;
    @(negedge fclk);
    while (!rdFrameReady && n < 200) begin
      @(negedge fclk);
      n++;
    end
    rdFrameValid = 1'b1;
    rdBufAddr    = base;
    rdFrameBytes = bytes;
    @(negedge fclk);
    rdFrameValid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge fclk);
    #2;
  endtask

  task automatic waitDone(input string tag, input int expDone, input int budget);
    int n = 0;
    while (doneCount < expDone && n < budget) begin
      @(negedge fclk);
      #2;
      n++;
    end
    checkOutput({tag, "_done_in_time"}, 64'(doneCount >= expDone), 64'd1);
    waitCycles(4);
  endtask

  task automatic checkBeats(input string tag, input logic [31:0] base, input int nBeats);
    int errs = 0;
    logic [63:0] exp;
    checkOutput({tag, "_nbeats"}, 64'(beatQ.size()), 64'(nBeats));
    for (int k = 0; k < beatQ.size(); k++) begin
      exp = {base + 32'(k / 16) * 32'd128, 28'h0, 4'(k % 16)};
      if (beatQ[k] !== exp) errs++;
    end
    checkOutput({tag, "_data_errs"}, 64'(errs), 64'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    rdFrameValid = 1'b0;
    rdBufAddr    = 32'd0;
    rdFrameBytes = 32'd0;
    doutSpace    = 8'd64;
    doutReady    = 1'b1;
    arreadyIn    = 1'b1;
    rvalidIn     = 1'b0;
    rdataIn      = 64'd0;
    rlastIn      = 1'b0;
    rrespIn      = 2'b00;
    repeat (3) @(negedge fclk);
    rst_n = 1'b1;
    waitCycles(1);

    $display("[TB] reset state");
    checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
    checkOutput("rst_araddr", 64'(araddr), 64'd0);
    checkOutput("rst_astate", 64'(debugAstate), 64'd0);
    checkOutput("rst_ready", 64'(rdFrameReady), 64'd1);
    checkOutput("rst_frame_done", 64'(frameDone), 64'd0);
    checkOutput("rst_rd_err", 64'(rdErr), 64'd0);
    checkOutput("const_arlen", 64'(arlen), 64'hF);
    checkOutput("const_arsize", 64'(arsize), 64'd3);
    checkOutput("const_arburst", 64'(arburst), 64'd1);

    $display("[TB] basic 256 B frame");
    clearMon();
    applyStimulus(32'h1000_0000, 32'd256);
    waitDone("t1", 1, 400);
    checkOutput("t1_arcount", 64'(arAddrQ.size()), 64'd2);
    checkOutput("t1_ar0", 64'(arAt(0)), 64'h1000_0000);
    checkOutput("t1_ar1", 64'(arAt(1)), 64'h1000_0080);
    checkBeats("t1", 32'h1000_0000, 32);
    checkOutput("t1_last_count", 64'(frameLastCount), 64'd1);
    checkOutput("t1_last_idx", 64'(frameLastIdx), 64'd31);
    checkOutput("t1_done_cycles", 64'(doneCount), 64'd1);
    checkOutput("t1_passthru", 64'(passViol), 64'd0);
    checkOutput("t1_idle", 64'(debugAstate), 64'd0);

    $display("[TB] ARREADY stall");
    clearMon();
    arreadyMode = 0;
    applyStimulus(32'h2000_0000, 32'd128);
    n = 0;
    while (!arvalid && n < 50) begin
      waitCycles(1);
      n++;
    end
    checkOutput("t2_arvalid_up", 64'(arvalid), 64'd1);
    waitCycles(5);
    arreadyMode = 1;
    waitDone("t2", 1, 400);
    checkOutput("t2_stall_cycles", 64'(arStallCycles >= 5), 64'd1);
    checkOutput("t2_stable", 64'(arStableViol), 64'd0);
    checkOutput("t2_arcount", 64'(arAddrQ.size()), 64'd1);
    checkOutput("t2_ar0", 64'(arAt(0)), 64'h2000_0000);
    checkBeats("t2", 32'h2000_0000, 16);

    $display("[TB] outstanding limit");
    clearMon();
    rEnable = 0;
    applyStimulus(32'h3000_0000, 32'd512);
    waitCycles(20);
    checkOutput("t3_arcount_held", 64'(arAddrQ.size()), 64'd2);
    rEnable = 1;
    waitDone("t3", 1, 600);
    checkOutput("t3_arcount", 64'(arAddrQ.size()), 64'd4);
    checkOutput("t3_third_after_rlast", 64'(arStamp.size() > 2 && arStamp[2] >= 16), 64'd1);
    checkOutput("t3_ar3", 64'(arAt(3)), 64'h3000_0180);
    checkBeats("t3", 32'h3000_0000, 64);
    checkOutput("t3_last_idx", 64'(frameLastIdx), 64'd63);

    $display("[TB] downstream space gating");
    clearMon();
    rEnable = 0;
    doutSpace = 8'd20;
    applyStimulus(32'h4000_0000, 32'd256);
    waitCycles(20);
    checkOutput("t4_arcount_space20", 64'(arAddrQ.size()), 64'd1);
    doutSpace = 8'd32;
    waitCycles(10);
    checkOutput("t4_arcount_space32", 64'(arAddrQ.size()), 64'd2);
    rEnable = 1;
    doutSpace = 8'd64;
    waitDone("t4", 1, 400);
    checkBeats("t4", 32'h4000_0000, 32);
    checkOutput("t4_last_count", 64'(frameLastCount), 64'd1);

    $display("[TB] dout_ready toggling");
    clearMon();
    readyMode = 2;
    applyStimulus(32'h5000_0000, 32'd384);
    waitDone("t5", 1, 800);
    readyMode = 1;
    checkBeats("t5", 32'h5000_0000, 48);
    checkOutput("t5_rready_mirror", 64'(rreadyViol), 64'd0);
    checkOutput("t5_passthru", 64'(passViol), 64'd0);
    checkOutput("t5_last_idx", 64'(frameLastIdx), 64'd47);
    checkOutput("t5_done_cycles", 64'(doneCount), 64'd1);

    $display("[TB] zero-length frame");
    clearMon();
    applyStimulus(32'h5555_0000, 32'd0);
    waitDone("t6", 1, 50);
    checkOutput("t6_arcount", 64'(arAddrQ.size()), 64'd0);
    checkOutput("t6_done_cycles", 64'(doneCount), 64'd1);
    checkOutput("t6_idle", 64'(debugAstate), 64'd0);

    $display("[TB] read response error");
    clearMon();
    errBeat = 4;
    applyStimulus(32'h6000_0000, 32'd128);
    waitDone("t7", 1, 400);
    errBeat = -1;
    checkOutput("t7_rd_err_sticky", 64'(rdErr), 64'(EXP_ERR));
    checkBeats("t7", 32'h6000_0000, 16);
    clearMon();
    applyStimulus(32'h6000_0080, 32'd0);
    #2;
    checkOutput("t7_rd_err_cleared", 64'(rdErr), 64'd0);
    waitDone("t7b", 1, 50);

    $display("[TB] reset mid-frame");
    clearMon();
    arreadyMode = 0;
    applyStimulus(32'h7000_0000, 32'd512);
    waitCycles(5);
    checkOutput("t8_arvalid_before", 64'(arvalid), 64'd1);
    checkOutput("t8_astate_before", 64'(debugAstate), 64'd1);
    @(negedge fclk);
    rst_n = 1'b0;
    #2;
    checkOutput("t8_arvalid_in_reset", 64'(arvalid), 64'd0);
    checkOutput("t8_astate_in_reset", 64'(debugAstate), 64'd0);
    repeat (2) @(negedge fclk);
    rst_n = 1'b1;
    arreadyMode = 1;
    waitCycles(1);
    checkOutput("t8_ready_after", 64'(rdFrameReady), 64'd1);
    checkOutput("t8_astate_after", 64'(debugAstate), 64'd0);
    checkOutput("t8_araddr_after", 64'(araddr), 64'd0);
    clearMon();
    applyStimulus(32'h0800_0000, 32'd128);
    waitDone("t8", 1, 400);
    checkBeats("t8", 32'h0800_0000, 16);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
